switch_box_config_loader: RTL

Deserializes a narrow configuration stream into the wide CONF_WIDTH configuration word consumed by the disjoint switch box, then pulses cset for one cycle to commit it. Sits directly upstream of the switch box. Its c/cset outputs connect straight to the switch box's c/cset inputs. Upstream it takes a valid/ready chunk stream from the fabric configuration controller.

---
 rtl/switch_box_config_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/switch_box_config_loader.sv
// rtl/switch_box_config_loader.sv - deserializes a chunk stream into a switch box configuration word
//
// Purpose:
//   Collects NCHUNK chunks of DATA_W bits (chunk 0 in the LSBs) into a wide
//   assembly register. On the last chunk handshake, the assembled word is
//   copied to c and cset pulses for one cycle to commit it to the switch box.
//   Between commits, c holds the last committed word.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   start      - begin a load (honoured only in IDLE)
//   abort      - cancel a load in progress (LOAD only), no commit
//   din        - configuration chunk
//   din_valid  - din carries a chunk
//   din_ready  - loader accepts din (high in LOAD)
//   c          - committed configuration word (registered)
//   cset       - one-cycle commit strobe
//   busy       - high in LOAD or COMMIT
//   chunk_cnt  - chunks accepted in the current load

module switch_box_config_loader #(
    parameter int CONF_WIDTH = 48,
    parameter int DATA_W     = 8,
    localparam int NCHUNK    = (CONF_WIDTH + DATA_W - 1) / DATA_W,
    localparam int CNT_W     = $clog2(NCHUNK + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [CONF_WIDTH-1:0] c,
    output logic                  cset,
    output logic                  busy,
    output logic [CNT_W-1:0]      chunk_cnt
);

    localparam int              ASM_W    = NCHUNK * DATA_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ASM_W-1:0]        r_asm;
    logic [ASM_W-1:0]        w_asm_next;
    logic [CONF_WIDTH-1:0]   r_c;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_xfer;
    logic                    w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the assembly word as it would look with the current
    // chunk inserted; that same word feeds c on the final handshake so the
    // last chunk is included without an extra cycle.
    always_comb begin
        w_next     = r_state;
        w_xfer     = 1'b0;
        w_last     = 1'b0;
        w_asm_next = r_asm;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_asm_next[k*DATA_W +: DATA_W] = din;
            end
        end
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_xfer = din_valid;
                w_last = din_valid && (r_cnt == LAST_IDX);
                // abort wins over a simultaneous last chunk
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_asm <= '0;
            r_cnt <= '0;
            r_c   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_asm <= '0;
                        r_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_asm <= '0;
                        r_cnt <= '0;
                    end else if (w_xfer) begin
                        r_asm <= w_asm_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            // bits of the final chunk above CONF_WIDTH-1 drop here
                            r_c <= w_asm_next[CONF_WIDTH-1:0];
                        end
                    end
                end
                S_COMMIT: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Status outputs decode the state register, so an async reset clears
    // them immediately without waiting for an edge.
    assign din_ready = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign cset      = (r_state == S_COMMIT);
    assign c         = r_c;
    assign chunk_cnt = r_cnt;

endmodule
